ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. It is the send direction that complements the existing keyboard receiver.
- Sits as a Wishbone-style slave on the intercon, on a free slave slot (5). The CPU writes one command byte, such as 0xED for set-LEDs or 0xFF for reset.
- The block runs the PS/2 host request-to-send sequence on the shared PS2C/PS2D lines, shifts out data, parity and stop bits, and checks the device ACK.
- Status and a completion interrupt are returned to the CPU.

---
 rtl/ps2_host_tx_pkg.sv | 31 +++
 rtl/ps2_host_tx_if.sv | 12 +
 rtl/ps2_line_sync.sv | 38 +++
 rtl/ps2_host_tx.sv | 183 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, status-word
// layout, default timing and the frame builder.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SHIFT,
    ST_WAIT_ACK,
    ST_DONE
  } state_t;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_NACK     = 2;
  localparam int STAT_TIMEOUT  = 3;
  localparam int STAT_OVR      = 4;
  localparam int STAT_LAST_LSB = 8;

  localparam int DEF_INHIBIT_CYCLES = 3000;
  localparam int DEF_TIMEOUT_CYCLES = 50000;

  localparam int FRAME_BITS = 10;

  // Shifted out LSB first: data[7:0], odd parity, stop.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// CPU-side slave port of the PS/2 host transmitter (Wishbone-style).
interface ps2_host_tx_if;
  logic        STB;
  logic        WE;
  logic [31:0] DAT_I;
  logic        ACK;
  logic [31:0] DAT_O;
  logic        INT;

  modport master (output STB, WE, DAT_I, input  ACK, DAT_O, INT);
  modport slave  (input  STB, WE, DAT_I, output ACK, DAT_O, INT);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for PS2C/PS2D plus a one-cycle PS2C falling-edge
// strobe; idle lines are high, so every flop resets to 1.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_c,
  input  logic i_d,
  output logic o_c_sync,
  output logic o_d_sync,
  output logic o_c_fe
);

  logic r_c_meta, r_c_sync, r_c_prev;
  logic r_d_meta, r_d_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a real shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_meta <= 1'b1;
      r_c_sync <= 1'b1;
      r_c_prev <= 1'b1;
      r_d_meta <= 1'b1;
      r_d_sync <= 1'b1;
    end else begin
      r_c_meta <= i_c;
      r_c_sync <= r_c_meta;
      r_c_prev <= r_c_sync;
      r_d_meta <= i_d;
      r_d_sync <= r_d_meta;
    end
  end

  assign o_c_sync = r_c_sync;
  assign o_d_sync = r_d_sync;
  assign o_c_fe   = r_c_prev & ~r_c_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 10-bit shift on device
// clock falling edges, ACK check, status word and completion interrupt.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave bus,
  input  logic         ps2c_in,
  input  logic         ps2d_in,
  output logic         ps2c_oe,
  output logic         ps2d_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t                r_state, w_state_nxt;
  logic [FRAME_BITS-1:0] r_shift, w_shift_nxt;
  logic [3:0]            r_bitcnt, w_bitcnt_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_c_oe, w_c_oe_nxt, r_d_oe, w_d_oe_nxt;
  logic                  r_done, w_done_nxt, r_nack, w_nack_nxt;
  logic                  r_timeout, w_timeout_nxt, r_ovr, w_ovr_nxt;
  logic [7:0]            r_last, w_last_nxt;
  logic                  r_int, w_int_nxt;
  logic                  r_ack;

  logic w_c_sync, w_d_sync, w_c_fe;
  logic w_busy, w_wr, w_rd, w_wd_expired;
  logic [31:0] w_status;
  logic w_unused_dat;

  ps2_line_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_c     (ps2c_in),
    .i_d     (ps2d_in),
    .o_c_sync(w_c_sync),
    .o_d_sync(w_d_sync),
    .o_c_fe  (w_c_fe)
  );

  assign w_busy       = (r_state != ST_IDLE);
  assign w_wr         = r_ack & bus.STB & bus.WE;
  assign w_rd         = r_ack & bus.STB & ~bus.WE;
  assign w_wd_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_unused_dat = ^bus.DAT_I[31:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack     <= 1'b0;
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_cnt     <= '0;
      r_c_oe    <= 1'b0;
      r_d_oe    <= 1'b0;
      r_done    <= 1'b0;
      r_nack    <= 1'b0;
      r_timeout <= 1'b0;
      r_ovr     <= 1'b0;
      r_last    <= '0;
      r_int     <= 1'b0;
    end else begin
      r_ack     <= bus.STB & ~r_ack;
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_cnt     <= w_cnt_nxt;
      r_c_oe    <= w_c_oe_nxt;
      r_d_oe    <= w_d_oe_nxt;
      r_done    <= w_done_nxt;
      r_nack    <= w_nack_nxt;
      r_timeout <= w_timeout_nxt;
      r_ovr     <= w_ovr_nxt;
      r_last    <= w_last_nxt;
      r_int     <= w_int_nxt;
    end
  end

  // NOTE: every output of this block is given a hold/default value first so
  // that no path through the case statement can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bitcnt_nxt  = r_bitcnt;
    w_cnt_nxt     = r_cnt;
    w_c_oe_nxt    = r_c_oe;
    w_d_oe_nxt    = r_d_oe;
    w_done_nxt    = r_done;
    w_nack_nxt    = r_nack;
    w_timeout_nxt = r_timeout;
    w_ovr_nxt     = r_ovr;
    w_last_nxt    = r_last;
    w_int_nxt     = 1'b0;

    // Read-clear first so a completion in the same cycle still lands.
    if (w_rd) begin
      w_done_nxt    = 1'b0;
      w_nack_nxt    = 1'b0;
      w_timeout_nxt = 1'b0;
      w_ovr_nxt     = 1'b0;
    end
    if (w_wr && w_busy) w_ovr_nxt = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (w_wr) begin
          w_last_nxt    = bus.DAT_I[7:0];
          w_shift_nxt   = build_frame(bus.DAT_I[7:0]);
          w_bitcnt_nxt  = '0;
          w_cnt_nxt     = '0;
          w_done_nxt    = 1'b0;
          w_nack_nxt    = 1'b0;
          w_timeout_nxt = 1'b0;
          w_c_oe_nxt    = 1'b1;
          w_state_nxt   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (r_cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
          w_d_oe_nxt  = 1'b1;
          w_state_nxt = ST_START;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_START: begin
        w_c_oe_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT, ST_WAIT_ACK, ST_DONE: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_wd_expired) begin
          w_c_oe_nxt    = 1'b0;
          w_d_oe_nxt    = 1'b0;
          w_timeout_nxt = 1'b1;
          w_int_nxt     = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else if (r_state == ST_SHIFT) begin
          if (w_c_fe) begin
            w_d_oe_nxt   = ~r_shift[0];
            w_shift_nxt  = {1'b0, r_shift[FRAME_BITS-1:1]};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            if (r_bitcnt == 4'(FRAME_BITS - 1)) w_state_nxt = ST_WAIT_ACK;
          end
        end else if (r_state == ST_WAIT_ACK) begin
          if (w_c_fe) begin
            if (w_d_sync) w_nack_nxt = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end else if (w_c_sync && w_d_sync) begin
          w_done_nxt  = 1'b1;
          w_int_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_status                         = '0;
    w_status[STAT_BUSY]              = w_busy;
    w_status[STAT_DONE]              = r_done;
    w_status[STAT_NACK]              = r_nack;
    w_status[STAT_TIMEOUT]           = r_timeout;
    w_status[STAT_OVR]               = r_ovr;
    w_status[STAT_LAST_LSB +: 8]     = r_last;
  end

  assign bus.ACK   = r_ack;
  assign bus.DAT_O = w_status;
  assign bus.INT   = r_int;
  assign ps2c_oe   = r_c_oe;
  assign ps2d_oe   = r_d_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int TO   = 600;
  localparam int HALF = 12;

  logic clk = 1'b0;
  logic rst;
  logic ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;
  logic dev_c_low = 1'b0;
  logic dev_d_low = 1'b0;

  always #20 clk = ~clk;

  assign ps2c_in = ~(ps2c_oe | dev_c_low);
  assign ps2d_in = ~(ps2d_oe | dev_d_low);

  ps2_host_tx_if bus ();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .ps2c_in(ps2c_in),
    .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe),
    .ps2d_oe(ps2d_oe)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  int   int_cnt = 0;
  int   c_low_cnt = 0;
  int   c_rise_cnt = 0;
  logic c_oe_q = 1'b0;

  always @(negedge clk) begin
    if (bus.INT) int_cnt++;
    if (ps2c_oe) c_low_cnt++;
    if (ps2c_oe && !c_oe_q) c_rise_cnt++;
    c_oe_q = ps2c_oe;
  end

  typedef struct {
    logic [7:0]  data;
    bit          ack_low;
    int          act_edge;
    int          act_kind;   // 0 none, 1 write 0xAA mid-frame
    logic [9:0]  exp_bits;
    logic [31:0] exp_stat;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] d);
    bit got = 0;
    @(negedge clk);
    bus.STB = 1'b1; bus.WE = 1'b1; bus.DAT_I = {24'hA5A5A5, d};
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (bus.ACK) got = 1;
    end
    check("write ack", bus.ACK, 1);
    @(negedge clk);
    bus.STB = 1'b0; bus.WE = 1'b0;
  endtask

  task automatic bus_read(output logic [31:0] d);
    bit got = 0;
    d = '0;
    @(negedge clk);
    bus.STB = 1'b1; bus.WE = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (bus.ACK) begin got = 1; d = bus.DAT_O; end
    end
    check("read ack", bus.ACK, 1);
    @(negedge clk);
    bus.STB = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_int(input int base);
    for (int n = 0; n < 200 && int_cnt == base; n++) @(negedge clk);
    wait_cycles(5);
    check("int pulses", int_cnt - base, 1);
  endtask

  // Device side: waits for clock release, clocks 10 bits, then ACK clock.
  task automatic dev_xfer(input bit ack_low, input int act_edge, input int act_kind,
                          output logic [9:0] bits, output logic start_bit);
    bits = '0;
    for (int n = 0; n < INH + 20 && ps2c_oe; n++) @(negedge clk);
    check("clock released", ps2c_oe, 0);
    start_bit = ps2d_in;
    wait_cycles(HALF);
    for (int k = 1; k <= 10; k++) begin
      dev_c_low = 1'b1;
      if (k == act_edge && act_kind == 1) begin
        wait_cycles(5);
        bus_write(8'hAA);
      end else if (k == act_edge && act_kind == 2) begin
        wait_cycles(5);
        rst = 1'b1;
        #1;
        check("rst c_oe", ps2c_oe, 0);
        check("rst d_oe", ps2d_oe, 0);
        wait_cycles(2);
        rst = 1'b0;
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        return;
      end
      wait_cycles(HALF);
      bits[k-1] = ps2d_in;
      dev_c_low = 1'b0;
      wait_cycles(HALF);
    end
    if (ack_low) dev_d_low = 1'b1;
    wait_cycles(HALF);
    dev_c_low = 1'b1;
    wait_cycles(HALF);
    dev_c_low = 1'b0;
    wait_cycles(HALF);
    dev_d_low = 1'b0;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] st;
    logic [9:0]  bits;
    logic        sb;
    int          base, clow_base, rise_base, n;
    logic        a0, a1, a2;

    vecs[0] = '{8'hED, 1'b1, 0, 0, 10'h3ED, 32'h0000ED02};
    vecs[1] = '{8'h00, 1'b0, 0, 0, 10'h300, 32'h00000006};
    vecs[2] = '{8'hF4, 1'b1, 4, 1, 10'h2F4, 32'h0000F412};
    vecs[3] = '{8'h5A, 1'b1, 0, 0, 10'h35A, 32'h00005A02};

    rst = 1'b1; bus.STB = 1'b0; bus.WE = 1'b0; bus.DAT_I = '0;
    wait_cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset ACK", bus.ACK, 0);
    check("reset INT", bus.INT, 0);
    check("reset c_oe", ps2c_oe, 0);
    check("reset d_oe", ps2d_oe, 0);
    check("reset DAT_O", bus.DAT_O, 0);

    // Device-held clock while idle has no effect.
    dev_c_low = 1'b1;
    wait_cycles(10);
    check("idle held clk status", bus.DAT_O, 0);
    check("idle held clk int", int_cnt, 0);
    dev_c_low = 1'b0;
    wait_cycles(HALF);

    // Reset after edge 5 of an 0xED frame.
    base = int_cnt;
    bus_write(8'hED);
    dev_xfer(1'b1, 5, 2, bits, sb);
    wait_cycles(10);
    check("no int after rst", int_cnt, base);
    bus_read(st);
    check("status after rst", st, 32'h0);

    foreach (vecs[i]) begin
      base      = int_cnt;
      clow_base = c_low_cnt;
      bus_write(vecs[i].data);
      dev_xfer(vecs[i].ack_low, vecs[i].act_edge, vecs[i].act_kind, bits, sb);
      check($sformatf("v%0d start bit", i), sb, 0);
      check($sformatf("v%0d frame", i), bits, vecs[i].exp_bits);
      check($sformatf("v%0d inhibit len", i), c_low_cnt - clow_base, INH + 1);
      wait_int(base);
      bus_read(st);
      check($sformatf("v%0d status", i), st, vecs[i].exp_stat);
      bus_read(st);
      check($sformatf("v%0d status cleared", i), st, {16'h0, vecs[i].data, 8'h00});
    end

    // Silent device: watchdog expiry.
    base = int_cnt;
    bus_write(8'hFF);
    for (int k = 0; k < INH + 20 && ps2c_oe; k++) @(negedge clk);
    check("to clock released", ps2c_oe, 0);
    n = 0;
    while (ps2d_oe && n < TO + 50) begin
      if (!ps2c_oe) n++;
      @(negedge clk);
    end
    check("to cycles", n, TO);
    check("to c_oe", ps2c_oe, 0);
    check("to d_oe", ps2d_oe, 0);
    wait_cycles(3);
    check("to int", int_cnt - base, 1);
    bus_read(st);
    check("to status", st, 32'h0000FF08);

    // STB held three cycles: single ACK, single transfer.
    base      = int_cnt;
    rise_base = c_rise_cnt;
    @(negedge clk);
    bus.STB = 1'b1; bus.WE = 1'b1; bus.DAT_I = 32'h0000003C;
    #1 a0 = bus.ACK;
    @(negedge clk); a1 = bus.ACK;
    @(negedge clk); a2 = bus.ACK;
    bus.STB = 1'b0; bus.WE = 1'b0;
    check("hold ack c0", a0, 0);
    check("hold ack c1", a1, 1);
    check("hold ack c2", a2, 0);
    dev_xfer(1'b1, 0, 0, bits, sb);
    check("hold frame", bits, 10'h33C);
    wait_int(base);
    check("hold transfers", c_rise_cnt - rise_base, 1);
    bus_read(st);
    check("hold status", st, 32'h00003C02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
